// File: rtl/regfile_pkg.sv
// Shared constants, dump sequencer state type and the write-bypass hit test
// used by both the read ports and the dump capture path.
package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

  // True when a write landing this edge targets the index being read.
  // Writes to R0 never hit, so R0 always reads back as zero.
  function automatic logic byp_hit(input logic              we,
                                   input logic [ADDR_W-1:0] waddr,
                                   input logic [ADDR_W-1:0] raddr);
    return we && (waddr != '0) && (waddr == raddr);
  endfunction
endpackage

// File: rtl/NBitThirtyTwoWayMux.sv
// Plain N-bit, 32-input selector over the packed register array.
module NBitThirtyTwoWayMux
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_COUNT-1:0][N-1:0] din,
  input  logic [ADDR_W-1:0]           sel,
  output logic [N-1:0]                dout
);
  assign dout = din[sel];
endmodule

// File: rtl/regfile_dump_seq.sv
// Full-file readout sequencer: walks R0..R31 once per dump_start, one beat
// per valid/ready handshake. The next beat's data is captured on the
// transferring edge, so later writes to that index cannot disturb a
// stalled beat.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        ready,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [N-1:0]                wdata,
  input  logic [REG_COUNT-1:0][N-1:0] regs,
  output logic                        valid,
  output logic                        busy,
  output logic [ADDR_W-1:0]           idx,
  output logic [N-1:0]                data
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  dump_state_e       state;
  logic [ADDR_W-1:0] nxt_idx;
  logic [N-1:0]      cap_raw;
  logic [N-1:0]      cap;

  assign nxt_idx = idx + 1'b1;

  NBitThirtyTwoWayMux #(.N(N)) u_cap_mux (
    .din  (regs),
    .sel  (nxt_idx),
    .dout (cap_raw)
  );

  // A write landing on the capture edge must be seen by the capture.
  assign cap = byp_hit(we, waddr, nxt_idx) ? wdata : cap_raw;

  // Handshake state, beat index and captured beat data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          idx   <= '0;
          data  <= '0;
        end
        SEND: if (ready) begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx  <= nxt_idx;
            data <= cap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid = (state == SEND);
  assign busy  = (state == SEND);
endmodule

// File: rtl/register_file_2r1w.sv
// 32 x N register file, two combinational read ports with write bypass,
// one write port, plus a handshaked full-file dump port. R0 is hardwired 0.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [N-1:0]      rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [N-1:0]      rdata_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [N-1:0]      dump_data
);
  localparam int NUM_RD = 2;

  logic [REG_COUNT-1:0][N-1:0] regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][N-1:0]      rmux;
  logic [NUM_RD-1:0][N-1:0]      rdata;

  // Register array; writes to index 0 are dropped so R0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    NBitThirtyTwoWayMux #(.N(N)) u_mux (
      .din  (regs),
      .sel  (raddr[p]),
      .dout (rmux[p])
    );
    assign rdata[p] = byp_hit(we, waddr, raddr[p]) ? wdata : rmux[p];
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

  regfile_dump_seq #(.N(N)) u_dump (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dump_start),
    .ready (dump_ready),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .regs  (regs),
    .valid (dump_valid),
    .busy  (dump_busy),
    .idx   (dump_idx),
    .data  (dump_data)
  );
endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 Parameter N, default 32, data width of every register, write port and read port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 we  input  1  write enable.
REQ-005 waddr  input  5  write register index.
REQ-006 wdata  input  N  write data.
REQ-007 raddr_a  input  5  read port A index.
REQ-008 rdata_a  output  N  read port A data.
REQ-009 raddr_b  input  5  read port B index.
REQ-010 rdata_b  output  N  read port B data.
REQ-011 dump_start  input  1  request full-file readout; sampled only in IDLE.
REQ-012 dump_busy  output  1  high while the dump sequencer is not IDLE.
REQ-013 dump_valid  output  1  dump beat valid.
REQ-014 dump_ready  input  1  consumer accepts dump beat.
REQ-015 dump_idx  output  5  register index of current dump beat.
REQ-016 dump_data  output  N  register contents of current dump beat.

Function
REQ-017 32 registers R0..R31 of N bits; R0 SHALL read 0 always, and writes to it SHALL be discarded.
REQ-018 When we=1 and waddr!=0, R[waddr] SHALL take wdata at the rising edge.
REQ-019 Read ports SHALL be combinational, zero-cycle latency, independent of each other and of the dump port.
REQ-020 Bypass: if we=1, waddr!=0, raddr_x==waddr, rdata_x SHALL equal wdata in that cycle; otherwise R[raddr_x].
REQ-021 Dump sequencer states: IDLE, SEND.
REQ-022 IDLE: dump_valid=0, dump_busy=0; dump_start=1 -> SEND at next edge, dump_idx=0, dump_data captured from R0 (0).
REQ-023 SEND: dump_valid=1, dump_busy=1; dump_idx and dump_data SHALL hold stable while dump_ready=0.
REQ-024 Beat transfer = dump_valid & dump_ready at a rising edge; on transfer with dump_idx<31, dump_idx increments and dump_data captures R[dump_idx+1] in the same edge.
REQ-025 Capture SHALL use the bypass rule of REQ-020: a same-edge write to the captured index yields wdata.
REQ-026 Writes to an already-captured index while a beat is stalled SHALL NOT change dump_data.
REQ-027 Transfer with dump_idx=31 -> IDLE; exactly 32 beats per dump, no wrap.
REQ-028 dump_start while SEND SHALL be ignored; dump_start on the same edge as the final transfer SHALL be ignored (IDLE entered first).
REQ-029 Register writes SHALL proceed unchanged during a dump.

Reset
REQ-030 rst_n=0 SHALL immediately clear R1..R31 to 0, force IDLE, and drive dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0.
REQ-031 Reset asserted mid-dump SHALL abort it; no further beats after release until a new dump_start.
REQ-032 Read outputs SHALL reflect cleared registers (0) during reset, bypass excepted.

Structure
REQ-033 Package regfile_pkg SHALL hold REG_COUNT=32, ADDR_W=5 and the dump state enum (IDLE, SEND).
REQ-034 Read ports A and B SHALL each be one NBitThirtyTwoWayMux instance selecting among R0..R31, bypass muxing after it.
REQ-035 The dump sequencer SHALL be one sub-module, regfile_dump_seq, holding state, index counter and capture register.

Verification
REQ-036 Write R5=0xDEADBEEF, next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; raddr_b=0 after we=1,waddr=0,wdata=0x1234 -> rdata_b=0.
REQ-037 Same cycle we=1,waddr=7,wdata=0xA5A5A5A5,raddr_a=7,raddr_b=7 (R7=0) -> both read 0xA5A5A5A5 in that cycle.
REQ-038 Preload Rk=k+0x100, dump_start, dump_ready=1 -> 32 consecutive beats idx 0..31, data 0,0x101..0x11F, then dump_busy=0.
REQ-039 Stall beat idx 3 (dump_ready=0, 4 cycles) while writing R3=0xFFFF and R4=0x4444 -> idx 3 data held at 0x103; idx 4 beat data 0x4444.
REQ-040 Assert rst_n=0 at beat idx 10 -> dump_valid=0, all reads 0 immediately; after release no beats until dump_start.
